// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI register command decoder.
package spi_cmd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StData,
    StChk,
    StCommit,
    StDrop
  } state_e;

  localparam logic [6:0] ADDR_RESULT = 7'h7E;
  localparam logic [6:0] ADDR_STATUS = 7'h7F;
  localparam logic [7:0] IDLE_BYTE   = 8'hA5;

  localparam int unsigned STAT_RV   = 0;
  localparam int unsigned STAT_ERR  = 1;
  localparam int unsigned STAT_BUSY = 2;

endpackage

// File: rtl/spi_cs_sync.sv
// Two-flop chip-select synchroniser with fall/rise pulses on the synchronised level.
module spi_cs_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic cs_n_i,
  output logic fall_o,
  output logic rise_o
);

  logic meta_q, sync_q, prev_q;

  // Idle level of chip-select is high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= cs_n_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign fall_o = prev_q & ~sync_q;
  assign rise_o = ~prev_q & sync_q;

endmodule

// File: rtl/spi_reg_cmd_decoder.sv
// Framed SPI byte-stream command decoder: register bank, result read-back, start/status.
// Optional SPI_CMD_CHKSUM_EN adds an XOR checksum byte to write and read frames.
module spi_reg_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned RES_W    = 4
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst_L,
  input  logic                         i_CS_n,
  input  logic                         i_RX_DV,
  input  logic [7:0]                   i_RX_Byte,
  output logic                         o_TX_DV,
  output logic [7:0]                   o_TX_Byte,
  output logic [NUM_REGS*DATA_W-1:0]   o_Reg_Flat,
  output logic [NUM_REGS-1:0]          o_Wr_Stb,
  input  logic [RES_W-1:0]             i_Result,
  input  logic                         i_Result_Valid,
  output logic                         o_Start,
  output logic                         o_Err
);

  localparam int unsigned NB   = DATA_W / 8;
  localparam logic [3:0]  LAST = 4'(NB - 1);

  state_e                       state_q;
  logic [3:0]                   cnt_q;
  logic [6:0]                   addr_q;
  logic                         rd_q;
  logic [DATA_W-1:0]            stage_q, tx_sr_q;
  logic [7:0]                   chk_q, tx_byte_q;
  logic [RES_W-1:0]             res_q;
  logic                         rv_q, err_q, busy_q, tx_dv_q, start_q;
  logic [NUM_REGS-1:0]          wr_stb_q;
  logic [NUM_REGS*DATA_W-1:0]   regs_q;

  logic cs_fall, cs_rise;

  spi_cs_sync u_cs_sync (
    .clk_i  (i_Clk),
    .rst_ni (i_Rst_L),
    .cs_n_i (i_CS_n),
    .fall_o (cs_fall),
    .rise_o (cs_rise)
  );

  logic              rx_ok, cmd_rd, is_reg, is_res, is_stat, cmd_bad;
  logic              commit_start, commit_clr, rv_clr, err_set;
  logic [6:0]        cmd_addr;
  logic [DATA_W-1:0] rd_word;
  logic [7:0]        rd_xor, tx_next;

  // A byte arriving with the CS rise belongs to no frame and is dropped.
  assign rx_ok    = i_RX_DV && !cs_rise && (state_q != StIdle);
  assign cmd_rd   = i_RX_Byte[7];
  assign cmd_addr = i_RX_Byte[6:0];
  assign is_reg   = 32'(cmd_addr) < NUM_REGS;
  assign is_res   = cmd_addr == ADDR_RESULT;
  assign is_stat  = cmd_addr == ADDR_STATUS;
  assign cmd_bad  = !(is_reg || is_res || is_stat) || (!cmd_rd && is_res);

  assign commit_start = (state_q == StCommit) && (addr_q == ADDR_STATUS) && stage_q[0];
  assign commit_clr   = (state_q == StCommit) && (addr_q == ADDR_STATUS) && stage_q[1];

  assign rv_clr = rx_ok && (
      (state_q == StCmd && cmd_rd && is_res && NB == 1) ||
      (state_q == StData && rd_q && addr_q == ADDR_RESULT && 32'(cnt_q) + 2 == NB));

  assign err_set = (rx_ok && state_q == StCmd && cmd_bad) ||
                   (rx_ok && state_q == StChk && i_RX_Byte != chk_q) ||
                   (commit_start && busy_q);

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (cmd_addr == 7'(k)) rd_word = regs_q[k*DATA_W +: DATA_W];
    end
    if (is_res) rd_word[RES_W-1:0] = res_q;
    if (is_stat) begin
      rd_word[STAT_RV]   = rv_q;
      rd_word[STAT_ERR]  = err_q;
      rd_word[STAT_BUSY] = busy_q;
    end
    rd_xor = '0;
    for (int i = 0; i < NB; i++) rd_xor = rd_xor ^ rd_word[i*8 +: 8];
  end

  always_comb begin
    tx_next = 8'h00;
    unique case (state_q)
      StCmd:  tx_next = (cmd_rd && !cmd_bad) ? rd_word[DATA_W-1 -: 8] : IDLE_BYTE;
      StData: begin
        if (rd_q) begin
          tx_next = tx_sr_q[DATA_W-1 -: 8];
`ifdef SPI_CMD_CHKSUM_EN
          if (cnt_q == LAST) tx_next = chk_q;
`endif
        end
      end
      default: tx_next = 8'h00;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      stage_q   <= '0;
      tx_sr_q   <= '0;
      chk_q     <= '0;
      tx_byte_q <= '0;
      res_q     <= '0;
      rv_q      <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      tx_dv_q   <= 1'b0;
      start_q   <= 1'b0;
      wr_stb_q  <= '0;
      regs_q    <= '0;
    end else begin
      tx_dv_q  <= rx_ok;
      wr_stb_q <= '0;
      start_q  <= 1'b0;
      if (rx_ok) tx_byte_q <= tx_next;
      if (i_Result_Valid) res_q <= i_Result;
      rv_q   <= i_Result_Valid | (rv_q & ~rv_clr);
      busy_q <= commit_start | (busy_q & ~i_Result_Valid);
      err_q  <= err_set | (err_q & ~commit_clr);

      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_q   <= StCmd;
            cnt_q     <= '0;
            tx_byte_q <= IDLE_BYTE;
          end
        end
        StCmd: begin
          if (rx_ok) begin
            addr_q <= cmd_addr;
            rd_q   <= cmd_rd;
            cnt_q  <= '0;
            if (cmd_bad) begin
              state_q <= StDrop;
            end else if (cmd_rd) begin
              // Whole word snapshotted here so a read never mixes old and new bytes.
              tx_sr_q <= rd_word << 8;
              chk_q   <= rd_xor;
              state_q <= StData;
            end else begin
              stage_q <= '0;
              chk_q   <= i_RX_Byte;
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (rx_ok) begin
            cnt_q <= cnt_q + 4'd1;
            if (rd_q) begin
              tx_sr_q <= tx_sr_q << 8;
            end else begin
              stage_q <= (stage_q << 8) | DATA_W'(i_RX_Byte);
              chk_q   <= chk_q ^ i_RX_Byte;
            end
            if (cnt_q == LAST) begin
`ifdef SPI_CMD_CHKSUM_EN
              state_q <= rd_q ? StDrop : StChk;
`else
              state_q <= rd_q ? StDrop : StCommit;
`endif
            end
          end
        end
        StChk: begin
          if (rx_ok) state_q <= (i_RX_Byte == chk_q) ? StCommit : StDrop;
        end
        StCommit: begin
          for (int k = 0; k < NUM_REGS; k++) begin
            if (addr_q == 7'(k)) begin
              regs_q[k*DATA_W +: DATA_W] <= stage_q;
              wr_stb_q[k]                <= 1'b1;
            end
          end
          start_q <= commit_start;
          state_q <= StDrop;
        end
        StDrop:  state_q <= StDrop;
        default: state_q <= StIdle;
      endcase

      if (cs_rise) state_q <= StIdle;
    end
  end

  assign o_TX_DV    = tx_dv_q;
  assign o_TX_Byte  = tx_byte_q;
  assign o_Reg_Flat = regs_q;
  assign o_Wr_Stb   = wr_stb_q;
  assign o_Start    = start_q;
  assign o_Err      = err_q;

endmodule

// File: tb/tb_spi_reg_cmd_decoder.sv
// Directed self-checking bench for spi_reg_cmd_decoder (DATA_W=16, NUM_REGS=4, RES_W=4).
module tb_spi_reg_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic [63:0] reg_flat;
  logic [3:0]  wr_stb;
  logic [3:0]  result = 4'h0;
  logic        result_valid = 1'b0;
  logic        start;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;
  int stb_cnt  = 0;
  int start_cnt = 0;
  logic [3:0] stb_last = 4'h0;

  spi_reg_cmd_decoder #(
    .DATA_W   (16),
    .NUM_REGS (4),
    .RES_W    (4)
  ) dut (
    .i_Clk          (clk),
    .i_Rst_L        (rst_n),
    .i_CS_n         (cs_n),
    .i_RX_DV        (rx_dv),
    .i_RX_Byte      (rx_byte),
    .o_TX_DV        (tx_dv),
    .o_TX_Byte      (tx_byte),
    .o_Reg_Flat     (reg_flat),
    .o_Wr_Stb       (wr_stb),
    .i_Result       (result),
    .i_Result_Valid (result_valid),
    .o_Start        (start),
    .o_Err          (err)
  );

  always #5 clk = ~clk;

  // Counts cycles during which each pulse output was high.
  always @(posedge clk) begin
    if (|wr_stb) begin
      stb_cnt  <= stb_cnt + 1;
      stb_last <= wr_stb;
    end
    if (start) start_cnt <= start_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    repeat (4) tick();
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic send(input logic [7:0] b, output logic [7:0] txb);
    rx_dv   = 1'b1;
    rx_byte = b;
    tick();
    rx_dv = 1'b0;
    check("tx_dv_pulse", 64'(tx_dv), 64'd1);
    txb = tx_byte;
    tick();
  endtask

  task automatic pulse_result(input logic [3:0] r);
    result       = r;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    tick();
  endtask

  // Returns the low byte of a 16-bit read frame.
  task automatic read_lsb(input logic [7:0] cmd, output logic [7:0] lsb);
    logic [7:0] t;
    cs_low();
    send(cmd, t);
    send(8'h00, lsb);
    cs_high();
  endtask

  task automatic write3(input logic [7:0] cmd, input logic [7:0] msb, input logic [7:0] lsb);
    logic [7:0] t;
    cs_low();
    send(cmd, t);
    send(msb, t);
    send(lsb, t);
    cs_high();
  endtask

  initial begin
    logic [7:0] t0, t1, t2;
    int s0, st0;

    repeat (3) tick();
    check("rst_regs", reg_flat, 64'h0);
    check("rst_tx_dv", 64'(tx_dv), 64'd0);
    check("rst_tx_byte", 64'(tx_byte), 64'h0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_start", 64'(start), 64'd0);
    check("rst_stb", 64'(wr_stb), 64'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Write reg1 = 0xBEEF.
    s0 = stb_cnt;
    cs_low();
    check("idle_byte_preload", 64'(tx_byte), 64'hA5);
    send(8'h01, t0);
    send(8'hBE, t1);
    send(8'hEF, t2);
    cs_high();
    check("wr_tx0", 64'(t0), 64'hA5);
    check("wr_tx1", 64'(t1), 64'h00);
    check("wr_reg1", reg_flat, 64'h0000_0000_BEEF_0000);
    check("wr_stb_cnt", 64'(stb_cnt - s0), 64'd1);
    check("wr_stb_val", 64'(stb_last), 64'h2);

    // Short frame to reg2 is discarded quietly.
    s0 = stb_cnt;
    cs_low();
    send(8'h02, t0);
    send(8'h12, t1);
    cs_high();
    check("short_regs", reg_flat, 64'h0000_0000_BEEF_0000);
    check("short_stb", 64'(stb_cnt - s0), 64'd0);
    check("short_err", 64'(err), 64'd0);

    // Result snapshot and read-back.
    pulse_result(4'hA);
    read_lsb(8'hFF, t0);
    check("stat_rv_set", 64'(t0), 64'h01);
    cs_low();
    check("rd_preload", 64'(tx_byte), 64'hA5);
    send(8'hFE, t0);
    send(8'h00, t1);
    send(8'h00, t2);
    cs_high();
    check("res_msb", 64'(t0), 64'h00);
    check("res_lsb", 64'(t1), 64'h0A);
    check("res_after", 64'(t2), 64'h00);
    read_lsb(8'hFF, t0);
    check("stat_rv_clr", 64'(t0), 64'h00);

    // Start pulse and busy.
    st0 = start_cnt;
    write3(8'h7F, 8'h00, 8'h01);
    check("start_cnt", 64'(start_cnt - st0), 64'd1);
    read_lsb(8'hFF, t0);
    check("stat_busy", 64'(t0), 64'h04);
    pulse_result(4'h3);
    read_lsb(8'hFF, t0);
    check("stat_done", 64'(t0), 64'h01);

    // Invalid address sets sticky err; STATUS bit1 clears it.
    cs_low();
    send(8'h40, t0);
    cs_high();
    check("inv_tx", 64'(t0), 64'hA5);
    check("inv_err", 64'(err), 64'd1);
    repeat (5) tick();
    check("inv_err_sticky", 64'(err), 64'd1);
    read_lsb(8'hFF, t0);
    check("stat_err", 64'(t0), 64'h03);
    st0 = start_cnt;
    write3(8'h7F, 8'h00, 8'h02);
    check("err_clr", 64'(err), 64'd0);
    check("clr_no_start", 64'(start_cnt - st0), 64'd0);

    // Address NUM_REGS is outside the bank, and RESULT is read-only.
    cs_low();
    send(8'h04, t0);
    cs_high();
    check("addr4_err", 64'(err), 64'd1);
    write3(8'h7F, 8'h00, 8'h02);
    write3(8'h7E, 8'h12, 8'h34);
    check("wr_result_err", 64'(err), 64'd1);
    write3(8'h7F, 8'h00, 8'h02);

    // Start while busy still pulses and flags err.
    st0 = start_cnt;
    write3(8'h7F, 8'h00, 8'h01);
    write3(8'h7F, 8'h00, 8'h01);
    check("busy_start_cnt", 64'(start_cnt - st0), 64'd2);
    check("busy_start_err", 64'(err), 64'd1);

    // Highest register, read back.
    write3(8'h03, 8'hC3, 8'h5A);
    check("reg3", reg_flat, 64'hC35A_0000_BEEF_0000);
    cs_low();
    send(8'h83, t0);
    send(8'h00, t1);
    cs_high();
    check("rd3_msb", 64'(t0), 64'hC3);
    check("rd3_lsb", 64'(t1), 64'h5A);

    // Reset in the middle of a write to reg0.
    s0 = stb_cnt;
    cs_low();
    send(8'h00, t0);
    send(8'h12, t1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_regs", reg_flat, 64'h0);
    check("mid_rst_err", 64'(err), 64'd0);
    check("mid_rst_tx", 64'(tx_byte), 64'h0);
    check("mid_rst_stb", 64'(wr_stb), 64'h0);
    cs_n = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("mid_rst_no_stb", 64'(stb_cnt - s0), 64'd0);
    write3(8'h00, 8'h12, 8'h34);
    check("post_rst_reg0", reg_flat, 64'h0000_0000_0000_1234);
    check("post_rst_stb", 64'(stb_last), 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_reg_cmd_decoder.md
Name: spi_reg_cmd_decoder

Overview:
- Byte-level command decoder between spi_peripheral (byte stream in the i_Clk domain) and an ML core (BNN_MLP-class datapath).
- Replaces a fixed three-register ad-hoc decoder with:
  - a parametrised register bank;
  - framed read/write commands;
  - a result read-back path;
  - start/status handshakes.
- Frames are delimited by SPI chip-select.
- Partial frames never corrupt registers.

Parameters:
- DATA_W, 16, register width in bits; multiple of 8, range 8..64; NB = DATA_W/8 bytes per transfer.
- NUM_REGS, 4, number of RW configuration registers at addresses 0..NUM_REGS-1; 1..126.
- RES_W, 4, width of the core result input; RES_W <= DATA_W.

Ports:
- i_Clk  in  1  system clock, same clock as spi_peripheral.
- i_Rst_L  in  1  reset; asynchronous assert, active-low.
- i_CS_n  in  1  raw SPI chip-select, active low; synchronised internally.
- i_RX_DV  in  1  one-cycle pulse from spi_peripheral: byte received.
- i_RX_Byte  in  8  received byte.
- o_TX_DV  out  1  one-cycle pulse that loads o_TX_Byte into spi_peripheral.
- o_TX_Byte  out  8  byte to shift out on the next SPI byte.
- o_Reg_Flat  out  NUM_REGS*DATA_W  register bank; reg k occupies bits [k*DATA_W +: DATA_W].
- o_Wr_Stb  out  NUM_REGS  one-cycle pulse on register k when reg k commits.
- i_Result  in  RES_W  core result.
- i_Result_Valid  in  1  one-cycle pulse: i_Result is valid.
- o_Start  out  1  one-cycle start pulse to the core.
- o_Err  out  1  sticky protocol error.

Behaviour:
- Reset (async, i_Rst_L=0):
  - All outputs 0, all registers 0, state IDLE.
  - Result snapshot 0; result_valid flag 0.
  - A frame in progress is abandoned; no commit.
- CS handling: 2-flop synchroniser on i_CS_n; fall and rise detected on the synchronised signal.
- Frame format: byte0 = command (bit7 = 1 read / 0 write; bits[6:0] = address), followed by NB data bytes, MSB byte first.
- Address map:
  - 0..NUM_REGS-1: RW registers.
  - 0x7E RESULT: read-only; i_Result zero-extended to DATA_W.
  - 0x7F STATUS: reads {.., busy, err, result_valid} in bits [2:0]; write bit0 = 1 pulses o_Start, write bit1 = 1 clears err.
  - Any other address is invalid.
- FSM states and transitions:
  - IDLE -> CMD on CS fall; byte counter cleared.
  - CMD, on RX_DV:
    - Invalid address, or write to RESULT: set err, go to DROP.
    - Read: snapshot the full DATA_W word into a TX shift register, go to DATA.
    - Write: clear the staging register, go to DATA.
  - DATA, on each RX_DV:
    - Write: shift the byte into the staging register.
    - Read: emit the next byte.
    - Counter increments; on byte NB-1 go to COMMIT (write) or DROP (read done).
  - COMMIT: lasts one cycle.
    - Staging -> reg[addr]; o_Wr_Stb[addr] = 1 for that cycle.
    - For STATUS: o_Start and err-clear act in this cycle.
    - Then go to DROP.
  - DROP: further bytes are ignored; o_TX_Byte = 0x00 on each RX_DV.
  - CS rise in any state -> IDLE the next cycle. A write with fewer than NB data bytes is discarded without setting err.
- TX timing:
  - o_TX_DV pulses exactly 1 cycle after every i_RX_DV while CS is active.
  - For a read, the pulse after the command byte carries data MSB byte; subsequent pulses carry the following bytes.
  - When there is no read data, the byte sent is 0xA5 (IDLE_BYTE) during CMD and 0x00 otherwise.
- Result path:
  - i_Result_Valid latches i_Result into the snapshot and sets result_valid.
  - result_valid clears when the last byte of a RESULT read is emitted.
  - If i_Result_Valid coincides with that clear, set wins.
  - A read returns the value snapshotted at CMD decode, never a mix of old and new bytes.
- Status bits:
  - busy = 1 from an o_Start pulse until the next i_Result_Valid.
  - A start written while busy still pulses o_Start and sets err.
- Simultaneous events: i_RX_DV in the same cycle as CS rise is dropped.

Optional Feature:
- Macro SPI_CMD_CHKSUM_EN.
- When defined:
  - Write frames carry one extra byte after the data: the XOR of the command byte and all data bytes.
  - Adds state CHK between DATA and COMMIT.
  - On mismatch: no commit, set err.
  - Read frames are unchanged, apart from one trailing XOR byte of the data emitted after the data.
- When undefined: no CHK state; writes commit directly after byte NB-1.

Decomposition:
- Package spi_cmd_pkg holds:
  - the state enum (IDLE, CMD, DATA, CHK, COMMIT, DROP);
  - ADDR_RESULT = 7'h7E, ADDR_STATUS = 7'h7F, IDLE_BYTE = 8'hA5;
  - STATUS bit indices.
- Sub-module spi_cs_sync: 2-flop synchroniser plus fall/rise pulse outputs.

Test Plan:
- Write reg1 with DATA_W=16: bytes 0x01, 0xBE, 0xEF then CS rise -> reg1 = 0xBEEF, o_Wr_Stb = 4'b0010 for 1 cycle; other registers unchanged.
- CS rise after 0x02, 0x12 (short frame) -> reg2 stays 0, no strobe, o_Err = 0.
- i_Result_Valid with i_Result = 4'hA, then read 0xFE, dummy, dummy -> TX bytes 0xA5, 0x00, 0x0A; STATUS bit0 then reads 0.
- Write 0x7F, 0x00, 0x01 -> single-cycle o_Start; STATUS reads busy = 1 until i_Result_Valid.
- Command 0x40 (invalid address) -> o_Err = 1 and sticky; write 0x7F, 0x00, 0x02 -> o_Err = 0.
- Assert i_Rst_L = 0 between data bytes of a write to reg0 -> all outputs 0, no strobe; the next full frame works.
